// File: rtl/uninasoc_pkg.sv
// Shared package for the uninasoc fabric blocks.
// Holds the memory-to-AXI4-Lite bridge FSM state encoding, the AXI response codes
// and a helper that classifies a response code as an error.
package uninasoc_pkg;

    // Bridge FSM states; only one transaction is ever in flight.
    typedef enum logic [2:0] {
        BRIDGE_IDLE    = 3'd0,
        BRIDGE_WR      = 3'd1,
        BRIDGE_WR_RESP = 3'd2,
        BRIDGE_RD_ADDR = 3'd3,
        BRIDGE_RD_DATA = 3'd4,
        BRIDGE_RESP    = 3'd5
    } bridge_state_e;

    // AXI response codes.
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // SLVERR and DECERR are errors; OKAY and EXOKAY are not.
    function automatic logic axi_resp_is_error(input logic [1:0] resp);
        logic err;
        err = 1'b0;
        case (resp)
            AXI_RESP_OKAY:                    err = 1'b0;
            AXI_RESP_SLVERR, AXI_RESP_DECERR: err = 1'b1;
            default:                          err = 1'b0;
        endcase
        return err;
    endfunction

endpackage : uninasoc_pkg

// File: rtl/mem_axil_bridge.sv
// Bridge from a simple req/gnt/valid memory port to an AXI4-Lite master.
//
// Ports:
//   clk_i, rst_i              single clock, synchronous active-high reset
//   mem_req_i / mem_gnt_o     request; grant is combinational and only given in IDLE
//   mem_addr_i, mem_we_i, mem_be_i, mem_wdata_i   request payload, latched on grant
//   mem_valid_o               one-cycle response pulse with mem_rdata_o / mem_error_o
//   m_axi_aw*, m_axi_w*, m_axi_b*, m_axi_ar*, m_axi_r*   AXI4-Lite master channels
//
// Optional build macro MEM_AXIL_TIMEOUT_EN adds a watchdog: a transaction stalled for
// TIMEOUT_CYCLES cycles is answered with an error, and any still-open AXI handshakes
// are drained silently before the next grant.
module mem_axil_bridge
    import uninasoc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    mem_req_i,
    output logic                    mem_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
    input  logic                    mem_we_i,
    input  logic [DATA_WIDTH/8-1:0] mem_be_i,
    input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
    output logic                    mem_valid_o,
    output logic [DATA_WIDTH-1:0]   mem_rdata_o,
    output logic                    mem_error_o,

    output logic                    m_axi_awvalid_o,
    input  logic                    m_axi_awready_i,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr_o,
    output logic [2:0]              m_axi_awprot_o,

    output logic                    m_axi_wvalid_o,
    input  logic                    m_axi_wready_i,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata_o,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb_o,

    input  logic                    m_axi_bvalid_i,
    output logic                    m_axi_bready_o,
    input  logic [1:0]              m_axi_bresp_i,

    output logic                    m_axi_arvalid_o,
    input  logic                    m_axi_arready_i,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr_o,
    output logic [2:0]              m_axi_arprot_o,

    input  logic                    m_axi_rvalid_i,
    output logic                    m_axi_rready_o,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata_i,
    input  logic [1:0]              m_axi_rresp_i
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    // The watchdog preloads 1 on grant, so a limit below 2 is meaningless.
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
        $error("mem_axil_bridge: TIMEOUT_CYCLES must be at least 2");
    end

    bridge_state_e           state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    we_q;
    logic [STRB_WIDTH-1:0]   be_q;
    logic [DATA_WIDTH-1:0]   wdata_q;

    logic                    awvalid_q;
    logic                    wvalid_q;
    logic                    bready_q;
    logic                    arvalid_q;
    logic                    rready_q;

    logic                    mem_valid_q;
    logic                    mem_error_q;
    logic [DATA_WIDTH-1:0]   mem_rdata_q;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic aw_ok, w_ok, wr_issue_done;
    logic gnt;

    // Channel handshakes and completion of the AW/W pair (either order, or together).
    always_comb begin
        aw_hs         = awvalid_q & m_axi_awready_i;
        w_hs          = wvalid_q  & m_axi_wready_i;
        b_hs          = bready_q  & m_axi_bvalid_i;
        ar_hs         = arvalid_q & m_axi_arready_i;
        r_hs          = rready_q  & m_axi_rvalid_i;
        aw_ok         = ~awvalid_q | m_axi_awready_i;
        w_ok          = ~wvalid_q  | m_axi_wready_i;
        wr_issue_done = we_q & (awvalid_q | wvalid_q) & aw_ok & w_ok;
    end

`ifdef MEM_AXIL_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_q;
    logic            drain_q;
    logic            busy;
    logic            completing;
    logic            axi_pending;

    // Watchdog qualifiers: which states count, and which cycles finish normally.
    always_comb begin
        busy        = (state_q == BRIDGE_WR)      || (state_q == BRIDGE_WR_RESP) ||
                      (state_q == BRIDGE_RD_ADDR) || (state_q == BRIDGE_RD_DATA);
        completing  = ((state_q == BRIDGE_WR_RESP) && b_hs) ||
                      ((state_q == BRIDGE_RD_DATA) && r_hs);
        axi_pending = awvalid_q | wvalid_q | bready_q | arvalid_q | rready_q;
    end

    // No new transaction while a timed-out one is still draining on AXI.
    assign gnt = mem_req_i & ~rst_i & ~drain_q & (state_q == BRIDGE_IDLE);
`else
    assign gnt = mem_req_i & ~rst_i & (state_q == BRIDGE_IDLE);
`endif

    // Bridge FSM, AXI channel flags and registered response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= BRIDGE_IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_error_q <= 1'b0;
            mem_rdata_q <= '0;
`ifdef MEM_AXIL_TIMEOUT_EN
            wd_q        <= '0;
            drain_q     <= 1'b0;
`endif
        end else begin
            // Channel flags follow their own handshakes regardless of state so that a
            // transaction abandoned by the watchdog still completes on the bus.
            if (aw_hs) awvalid_q <= 1'b0;
            if (w_hs)  wvalid_q  <= 1'b0;
            if (wr_issue_done) bready_q <= 1'b1;
            if (b_hs)  bready_q  <= 1'b0;
            if (ar_hs) begin
                arvalid_q <= 1'b0;
                rready_q  <= 1'b1;
            end
            if (r_hs)  rready_q  <= 1'b0;

            mem_valid_q <= 1'b0;

            case (state_q)
                BRIDGE_IDLE: begin
                    if (gnt) begin
                        addr_q  <= mem_addr_i;
                        we_q    <= mem_we_i;
                        be_q    <= mem_be_i;
                        wdata_q <= mem_wdata_i;
`ifdef MEM_AXIL_TIMEOUT_EN
                        // Preload 1 so the count includes the grant cycle.
                        wd_q    <= WD_W'(1);
`endif
                        if (mem_we_i) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= BRIDGE_WR;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= BRIDGE_RD_ADDR;
                        end
                    end
                end
                BRIDGE_WR: begin
                    if (wr_issue_done) state_q <= BRIDGE_WR_RESP;
                end
                BRIDGE_WR_RESP: begin
                    if (b_hs) begin
                        mem_valid_q <= 1'b1;
                        mem_error_q <= axi_resp_is_error(m_axi_bresp_i);
                        mem_rdata_q <= '0;
                        state_q     <= BRIDGE_RESP;
                    end
                end
                BRIDGE_RD_ADDR: begin
                    if (ar_hs) state_q <= BRIDGE_RD_DATA;
                end
                BRIDGE_RD_DATA: begin
                    if (r_hs) begin
                        mem_valid_q <= 1'b1;
                        mem_error_q <= axi_resp_is_error(m_axi_rresp_i);
                        mem_rdata_q <= m_axi_rdata_i;
                        state_q     <= BRIDGE_RESP;
                    end
                end
                BRIDGE_RESP: begin
                    state_q <= BRIDGE_IDLE;
                end
                default: begin
                    state_q <= BRIDGE_IDLE;
                end
            endcase

`ifdef MEM_AXIL_TIMEOUT_EN
            if (drain_q && !axi_pending) drain_q <= 1'b0;
            // A real completion on the limit cycle wins over the timeout.
            if (busy) begin
                if ((wd_q == WD_W'(TIMEOUT_CYCLES - 1)) && !completing) begin
                    state_q     <= BRIDGE_RESP;
                    mem_valid_q <= 1'b1;
                    mem_error_q <= 1'b1;
                    mem_rdata_q <= '0;
                    drain_q     <= 1'b1;
                end else begin
                    wd_q <= wd_q + WD_W'(1);
                end
            end
`endif
        end
    end

    assign mem_gnt_o       = gnt;
    assign mem_valid_o     = mem_valid_q;
    assign mem_error_o     = mem_error_q;
    assign mem_rdata_o     = mem_rdata_q;

    assign m_axi_awvalid_o = awvalid_q;
    assign m_axi_awaddr_o  = addr_q;
    assign m_axi_awprot_o  = 3'b000;
    assign m_axi_wvalid_o  = wvalid_q;
    assign m_axi_wdata_o   = wdata_q;
    assign m_axi_wstrb_o   = be_q;
    assign m_axi_bready_o  = bready_q;
    assign m_axi_arvalid_o = arvalid_q;
    assign m_axi_araddr_o  = addr_q;
    assign m_axi_arprot_o  = 3'b000;
    assign m_axi_rready_o  = rready_q;

endmodule : mem_axil_bridge

// File: tb/tb_mem_axil_bridge.sv
// Self-checking bench for mem_axil_bridge: an AXI4-Lite slave model with per-channel
// wait states, and a scoreboard of expected memory-port responses.
module tb_mem_axil_bridge;
    import uninasoc_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_req_i;
    logic        mem_gnt_o;
    logic [31:0] mem_addr_i;
    logic        mem_we_i;
    logic [3:0]  mem_be_i;
    logic [31:0] mem_wdata_i;
    logic        mem_valid_o;
    logic [31:0] mem_rdata_o;
    logic        mem_error_o;
    logic        m_axi_awvalid_o, m_axi_awready_i;
    logic [31:0] m_axi_awaddr_o;
    logic [2:0]  m_axi_awprot_o;
    logic        m_axi_wvalid_o, m_axi_wready_i;
    logic [31:0] m_axi_wdata_o;
    logic [3:0]  m_axi_wstrb_o;
    logic        m_axi_bvalid_i, m_axi_bready_o;
    logic [1:0]  m_axi_bresp_i;
    logic        m_axi_arvalid_o, m_axi_arready_i;
    logic [31:0] m_axi_araddr_o;
    logic [2:0]  m_axi_arprot_o;
    logic        m_axi_rvalid_i, m_axi_rready_o;
    logic [31:0] m_axi_rdata_i;
    logic [1:0]  m_axi_rresp_i;

    mem_axil_bridge #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .mem_req_i      (mem_req_i),
        .mem_gnt_o      (mem_gnt_o),
        .mem_addr_i     (mem_addr_i),
        .mem_we_i       (mem_we_i),
        .mem_be_i       (mem_be_i),
        .mem_wdata_i    (mem_wdata_i),
        .mem_valid_o    (mem_valid_o),
        .mem_rdata_o    (mem_rdata_o),
        .mem_error_o    (mem_error_o),
        .m_axi_awvalid_o(m_axi_awvalid_o),
        .m_axi_awready_i(m_axi_awready_i),
        .m_axi_awaddr_o (m_axi_awaddr_o),
        .m_axi_awprot_o (m_axi_awprot_o),
        .m_axi_wvalid_o (m_axi_wvalid_o),
        .m_axi_wready_i (m_axi_wready_i),
        .m_axi_wdata_o  (m_axi_wdata_o),
        .m_axi_wstrb_o  (m_axi_wstrb_o),
        .m_axi_bvalid_i (m_axi_bvalid_i),
        .m_axi_bready_o (m_axi_bready_o),
        .m_axi_bresp_i  (m_axi_bresp_i),
        .m_axi_arvalid_o(m_axi_arvalid_o),
        .m_axi_arready_i(m_axi_arready_i),
        .m_axi_araddr_o (m_axi_araddr_o),
        .m_axi_arprot_o (m_axi_arprot_o),
        .m_axi_rvalid_i (m_axi_rvalid_i),
        .m_axi_rready_o (m_axi_rready_o),
        .m_axi_rdata_i  (m_axi_rdata_i),
        .m_axi_rresp_i  (m_axi_rresp_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          gcyc;
        int          lat;
    } exp_t;
    exp_t sb[$];

    // Slave configuration.
    int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    logic [1:0]  b_resp_cfg = AXI_RESP_OKAY;
    logic [1:0]  r_resp_cfg = AXI_RESP_OKAY;
    logic [31:0] r_data_cfg = 32'h0;
    bit          r_use_addr = 1'b0;

    // Handshake log, written only by the posedge observer.
    int          grants = 0, aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0, b_cyc = 0;
    logic [31:0] log_awaddr = '0, log_wdata = '0, log_araddr = '0;
    logic [3:0]  log_wstrb = '0;
    logic [2:0]  log_awprot = '0, log_arprot = '0;
    int          valids = 0;
    int          abandoned = 0;

    // Observe handshakes and grants on the rising edge (pre-update values).
    always @(posedge clk_i) begin
        if (!rst_i) begin
            if (mem_req_i && mem_gnt_o) begin
                checks++;
                if (grants - valids - abandoned != 0) begin
                    errors++;
                    $display("FAIL grant_while_busy: outstanding=%0d required 0 at cycle %0d",
                             grants - valids - abandoned, cyc);
                end
                grants++;
            end
            if (m_axi_awvalid_o && m_axi_awready_i) begin
                aw_n++; log_awaddr = m_axi_awaddr_o; log_awprot = m_axi_awprot_o;
            end
            if (m_axi_wvalid_o && m_axi_wready_i) begin
                w_n++; log_wdata = m_axi_wdata_o; log_wstrb = m_axi_wstrb_o;
            end
            if (m_axi_bvalid_i && m_axi_bready_o) begin
                b_n++; b_cyc = cyc;
            end
            if (m_axi_arvalid_o && m_axi_arready_i) begin
                ar_n++; log_araddr = m_axi_araddr_o; log_arprot = m_axi_arprot_o;
            end
            if (m_axi_rvalid_i && m_axi_rready_o) r_n++;
        end
        cyc++;
    end

    // AXI4-Lite slave model, driven on the falling edge.
    int          aw_seen = 0, w_seen = 0, b_seen = 0, ar_seen = 0, r_seen = 0;
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    bit          aw_acc = 0, w_acc = 0, b_pend = 0, r_pend = 0;
    logic [31:0] r_addr_cur = '0;

    always @(negedge clk_i) begin
        if (rst_i) begin
            m_axi_awready_i = 0; m_axi_wready_i = 0; m_axi_bvalid_i = 0;
            m_axi_arready_i = 0; m_axi_rvalid_i = 0;
            m_axi_bresp_i = 2'b00; m_axi_rresp_i = 2'b00; m_axi_rdata_i = '0;
            aw_acc = 0; w_acc = 0; b_pend = 0; r_pend = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            aw_seen = aw_n; w_seen = w_n; b_seen = b_n; ar_seen = ar_n; r_seen = r_n;
        end else begin
            if (aw_n != aw_seen) begin
                aw_seen = aw_n; m_axi_awready_i = 0; aw_cnt = 0; aw_acc = 1;
            end else if (m_axi_awvalid_o && !m_axi_awready_i) begin
                if (aw_cnt >= aw_wait) m_axi_awready_i = 1; else aw_cnt++;
            end
            if (w_n != w_seen) begin
                w_seen = w_n; m_axi_wready_i = 0; w_cnt = 0; w_acc = 1;
            end else if (m_axi_wvalid_o && !m_axi_wready_i) begin
                if (w_cnt >= w_wait) m_axi_wready_i = 1; else w_cnt++;
            end
            if (b_n != b_seen) begin
                b_seen = b_n; m_axi_bvalid_i = 0; b_pend = 0;
            end
            if (aw_acc && w_acc) begin
                aw_acc = 0; w_acc = 0; b_pend = 1; b_cnt = 0;
            end
            if (b_pend && !m_axi_bvalid_i) begin
                if (b_cnt >= b_wait) begin
                    m_axi_bvalid_i = 1; m_axi_bresp_i = b_resp_cfg;
                end else b_cnt++;
            end
            if (ar_n != ar_seen) begin
                ar_seen = ar_n; m_axi_arready_i = 0; ar_cnt = 0;
                r_pend = 1; r_cnt = 0; r_addr_cur = log_araddr;
            end else if (m_axi_arvalid_o && !m_axi_arready_i) begin
                if (ar_cnt >= ar_wait) m_axi_arready_i = 1; else ar_cnt++;
            end
            if (r_n != r_seen) begin
                r_seen = r_n; m_axi_rvalid_i = 0; r_pend = 0;
            end
            if (r_pend && !m_axi_rvalid_i) begin
                if (r_cnt >= r_wait) begin
                    m_axi_rvalid_i = 1;
                    m_axi_rresp_i  = r_resp_cfg;
                    m_axi_rdata_i  = r_use_addr ? (r_addr_cur ^ 32'h5A5A_0000) : r_data_cfg;
                end else r_cnt++;
            end
        end
    end

    // Response monitor: every mem_valid_o pulse must match the oldest expectation.
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_i && mem_valid_o) begin
            valids++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: mem_valid_o=1 with nothing outstanding at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                if (mem_rdata_o !== e.rdata) begin
                    errors++;
                    $display("FAIL resp_rdata: got %h required %h", mem_rdata_o, e.rdata);
                end
                checks++;
                if (mem_error_o !== e.err) begin
                    errors++;
                    $display("FAIL resp_error: got %b required %b", mem_error_o, e.err);
                end
                if (e.lat >= 0) begin
                    checks++;
                    if (cyc - e.gcyc != e.lat) begin
                        errors++;
                        $display("FAIL resp_latency: got %0d required %0d", cyc - e.gcyc, e.lat);
                    end
                end
            end
        end
    end

    // Present one request, wait (bounded) for its grant and push the expectation.
    task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic [31:0] wdata, input logic [31:0] erd, input logic eerr,
                         input int elat, input bit keep, output int gcyc);
        exp_t e;
        bit   got;
        got = 0;
        gcyc = -1;
        mem_req_i = 1; mem_addr_i = addr; mem_we_i = we; mem_be_i = be; mem_wdata_i = wdata;
        for (int n = 0; n < 200; n++) begin
            #1;
            if (mem_gnt_o === 1'b1) begin got = 1; break; end
            @(negedge clk_i);
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL grant_wait: no grant for addr %h within 200 cycles", addr);
            mem_req_i = 0;
            return;
        end
        gcyc = cyc;
        e.rdata = erd; e.err = eerr; e.gcyc = cyc; e.lat = elat;
        sb.push_back(e);
        @(negedge clk_i);
        if (!keep) mem_req_i = 0;
    endtask

    task automatic wait_done();
        int n;
        for (n = 0; n < 300 && sb.size() != 0; n++) @(negedge clk_i);
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL resp_wait: %0d responses still missing", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_i = 1; mem_req_i = 1; mem_addr_i = 32'hFFFF_FFFF; mem_we_i = 1;
        mem_be_i = 4'hF; mem_wdata_i = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk_i);
        #1;
        checks++;
        if ({m_axi_awvalid_o, m_axi_wvalid_o, m_axi_bready_o, m_axi_arvalid_o, m_axi_rready_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_axi_flags: got %b required 00000",
                     {m_axi_awvalid_o, m_axi_wvalid_o, m_axi_bready_o, m_axi_arvalid_o, m_axi_rready_o});
        end
        checks++;
        if ({mem_gnt_o, mem_valid_o, mem_error_o} !== 3'b0) begin
            errors++;
            $display("FAIL reset_mem_flags: got %b required 000", {mem_gnt_o, mem_valid_o, mem_error_o});
        end
        checks++;
        if ({mem_rdata_o, m_axi_awaddr_o, m_axi_wdata_o} !== 96'b0) begin
            errors++;
            $display("FAIL reset_data: rdata %h awaddr %h wdata %h required 0",
                     mem_rdata_o, m_axi_awaddr_o, m_axi_wdata_o);
        end
        mem_req_i = 0;
        @(negedge clk_i);
        rst_i = 0;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_read_basic();
        int g, a0;
        a0 = ar_n;
        r_use_addr = 0; r_data_cfg = 32'hDEAD_BEEF; r_resp_cfg = AXI_RESP_OKAY;
        issue(32'h0000_1000, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 1'b0, g);
        wait_done();
        checks++;
        if (ar_n - a0 != 1 || log_araddr !== 32'h0000_1000 || log_arprot !== 3'b000) begin
            errors++;
            $display("FAIL read_ar: count %0d addr %h prot %b required 1 00001000 000",
                     ar_n - a0, log_araddr, log_arprot);
        end
    endtask

    task automatic test_write_skew();
        int g, a0, w0, v0;
        a0 = aw_n; w0 = w_n; v0 = valids;
        aw_wait = 0; w_wait = 2; b_resp_cfg = AXI_RESP_OKAY;
        issue(32'h0000_2004, 1'b1, 4'b0011, 32'h1234_5678, 32'h0, 1'b0, -1, 1'b0, g);
        wait_done();
        w_wait = 0;
        checks++;
        if (aw_n - a0 != 1 || w_n - w0 != 1) begin
            errors++;
            $display("FAIL write_hs_count: aw %0d w %0d required 1 1", aw_n - a0, w_n - w0);
        end
        checks++;
        if (log_awaddr !== 32'h0000_2004 || log_wdata !== 32'h1234_5678 ||
            log_wstrb !== 4'b0011 || log_awprot !== 3'b000) begin
            errors++;
            $display("FAIL write_payload: addr %h data %h strb %b prot %b required 00002004 12345678 0011 000",
                     log_awaddr, log_wdata, log_wstrb, log_awprot);
        end
        checks++;
        if (valids - v0 != 1) begin
            errors++;
            $display("FAIL write_valid_count: got %0d required 1", valids - v0);
        end
    endtask

    task automatic test_errors();
        int g, a0;
        r_resp_cfg = AXI_RESP_DECERR; r_data_cfg = 32'hCAFE_F00D;
        issue(32'h0000_0040, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b1, 3, 1'b0, g);
        wait_done();
        r_resp_cfg = AXI_RESP_OKAY;
        b_resp_cfg = AXI_RESP_SLVERR;
        issue(32'h0000_0044, 1'b1, 4'hF, 32'hAAAA_5555, 32'h0, 1'b1, 3, 1'b0, g);
        wait_done();
        b_resp_cfg = AXI_RESP_OKAY;
        a0 = aw_n;
        issue(32'h0000_0048, 1'b1, 4'h0, 32'h0BAD_0BAD, 32'h0, 1'b0, 3, 1'b0, g);
        wait_done();
        checks++;
        if (aw_n - a0 != 1 || log_wstrb !== 4'h0 || log_wdata !== 32'h0BAD_0BAD) begin
            errors++;
            $display("FAIL zero_be_write: aw %0d strb %b data %h required 1 0000 0badobad",
                     aw_n - a0, log_wstrb, log_wdata);
        end
    endtask

    task automatic test_back_to_back();
        int g0, g1, g2, gr0;
        gr0 = grants;
        r_use_addr = 1;
        issue(32'h0000_0100, 1'b0, 4'hF, 32'h0, 32'h0000_0100 ^ 32'h5A5A_0000, 1'b0, 3, 1'b1, g0);
        issue(32'h0000_0104, 1'b1, 4'hF, 32'h7777_1111, 32'h0, 1'b0, 3, 1'b1, g1);
        issue(32'h0000_0108, 1'b0, 4'hF, 32'h0, 32'h0000_0108 ^ 32'h5A5A_0000, 1'b0, 3, 1'b0, g2);
        wait_done();
        r_use_addr = 0;
        checks++;
        if (grants - gr0 != 3) begin
            errors++;
            $display("FAIL b2b_grants: got %0d required 3", grants - gr0);
        end
        checks++;
        if (g1 - g0 != 4 || g2 - g1 != 4) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d %0d required 4 4", g1 - g0, g2 - g1);
        end
    endtask

    task automatic test_reset_mid();
        int g, v0, n;
        r_wait = 20;
        issue(32'h0000_0200, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, -1, 1'b0, g);
        for (n = 0; n < 50 && m_axi_rready_o !== 1'b1; n++) @(negedge clk_i);
        checks++;
        if (m_axi_rready_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_reach_rd_data: rready %b required 1", m_axi_rready_o);
        end
        rst_i = 1;
        @(negedge clk_i);
        #1;
        checks++;
        if ({m_axi_awvalid_o, m_axi_wvalid_o, m_axi_bready_o, m_axi_arvalid_o, m_axi_rready_o,
             mem_valid_o, mem_error_o, mem_gnt_o} !== 8'b0 || mem_rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: flags %b rdata %h required 0",
                     {m_axi_awvalid_o, m_axi_wvalid_o, m_axi_bready_o, m_axi_arvalid_o,
                      m_axi_rready_o, mem_valid_o, mem_error_o, mem_gnt_o}, mem_rdata_o);
        end
        sb.delete();
        abandoned = grants - valids;
        r_wait = 0;
        @(negedge clk_i);
        rst_i = 0;
        v0 = valids;
        repeat (10) @(negedge clk_i);
        checks++;
        if (valids != v0) begin
            errors++;
            $display("FAIL mid_no_pulse: got %0d pulses required 0", valids - v0);
        end
        r_data_cfg = 32'h0F0F_1234;
        issue(32'h0000_0204, 1'b0, 4'hF, 32'h0, 32'h0F0F_1234, 1'b0, 3, 1'b0, g);
        wait_done();
    endtask

`ifdef MEM_AXIL_TIMEOUT_EN
    task automatic test_timeout();
        int gw, gr, b0, v0;
        b0 = b_n; v0 = valids;
        b_wait = 40;
        r_data_cfg = 32'h5555_AAAA;
        issue(32'h0000_3000, 1'b1, 4'hF, 32'h1357_9BDF, 32'h0, 1'b1, 16, 1'b1, gw);
        issue(32'h0000_3004, 1'b0, 4'hF, 32'h0, 32'h5555_AAAA, 1'b0, 3, 1'b0, gr);
        wait_done();
        b_wait = 0;
        checks++;
        if (b_n - b0 != 1 || gr <= b_cyc) begin
            errors++;
            $display("FAIL timeout_drain: b count %0d grant cycle %0d b cycle %0d required 1 and grant after b",
                     b_n - b0, gr, b_cyc);
        end
        checks++;
        if (valids - v0 != 2) begin
            errors++;
            $display("FAIL timeout_pulses: got %0d required 2", valids - v0);
        end
    endtask
`endif

    initial begin
        mem_req_i = 0; mem_addr_i = '0; mem_we_i = 0; mem_be_i = '0; mem_wdata_i = '0;
        rst_i = 1;
        test_reset();
        test_read_basic();
        test_write_skew();
        test_errors();
        test_back_to_back();
        test_reset_mid();
`ifdef MEM_AXIL_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule : tb_mem_axil_bridge

// File: doc/mem_axil_bridge.md
MEM_AXIL_BRIDGE -- requirements
Module: mem_axil_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width on both sides.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width on both sides; strobe width is DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, watchdog limit; used only when timeout is compiled in.
REQ-004 SHALL have clk_i  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have mem_req_i  in  1  MEM request.
REQ-007 SHALL have mem_gnt_o  out  1  MEM grant; request accepted this cycle.
REQ-008 SHALL have mem_addr_i  in  ADDR_WIDTH  request address.
REQ-009 SHALL have mem_we_i / mem_be_i / mem_wdata_i  in  1 / DATA_WIDTH/8 / DATA_WIDTH  write enable, byte enables, write data.
REQ-010 SHALL have mem_valid_o  out  1  one-cycle response pulse.
REQ-011 SHALL have mem_rdata_o / mem_error_o  out  DATA_WIDTH / 1  read data; response error.
REQ-012 SHALL have AXI4-Lite master channels m_axi_aw{valid out 1, ready in 1, addr out ADDR_WIDTH, prot out 3}, m_axi_w{valid out, ready in, data out DATA_WIDTH, strb out DATA_WIDTH/8}, m_axi_b{valid in, ready out, resp in 2}, m_axi_ar{valid out, ready in, addr out ADDR_WIDTH, prot out 3}, m_axi_r{valid in, ready out, data in DATA_WIDTH, resp in 2}.

Function
REQ-013 SHALL implement FSM IDLE, WR (AW/W pending), WR_RESP, RD_ADDR, RD_DATA, RESP; exactly one outstanding transaction.
REQ-014 In IDLE, SHALL assert mem_gnt_o combinationally when mem_req_i=1; latch addr/we/be/wdata; go to WR if mem_we_i=1, else RD_ADDR.
REQ-015 mem_gnt_o SHALL be 0 in every state other than IDLE.
REQ-016 WR: SHALL assert awvalid and wvalid together from the cycle after grant; each drops independently on its own handshake; go to WR_RESP once both have completed (same or different cycles).
REQ-017 WR_RESP: bready=1; on bvalid, capture bresp and go to RESP.
REQ-018 RD_ADDR: arvalid=1 until arready; then RD_DATA with rready=1; on rvalid, capture rdata/rresp and go to RESP.
REQ-019 RESP: mem_valid_o=1 for exactly one cycle; mem_error_o=1 iff captured resp[1]=1 (SLVERR/DECERR); mem_rdata_o=captured rdata for reads, 0 for writes; return to IDLE.
REQ-020 Minimum latency, zero-wait AXI slave: grant at cycle 0, mem_valid_o at cycle 3 for reads and writes; next grant possible at cycle 4.
REQ-021 awprot/arprot SHALL be 3'b000; awaddr/araddr/wdata/wstrb SHALL be stable while the matching valid is high.
REQ-022 Write with mem_be_i=0 SHALL still issue AW/W with wstrb=0.

Reset
REQ-023 On rst_i=1: FSM to IDLE; all valid/ready outputs, mem_gnt_o, mem_valid_o, mem_error_o 0; mem_rdata_o 0; latched registers 0; watchdog counter 0.
REQ-024 Reset mid-transaction SHALL abandon it without any mem_valid_o pulse; first cycle after reset deassertion is IDLE.

Configuration
REQ-025 Macro MEM_AXIL_TIMEOUT_EN SHALL compile in a watchdog counting cycles in WR, WR_RESP, RD_ADDR, RD_DATA.
REQ-026 With it: at count=TIMEOUT_CYCLES-1 the bridge SHALL go to RESP with mem_error_o=1, mem_rdata_o=0, keep pending AXI valid/ready signals asserted, set a drain flag, and hold mem_gnt_o=0 until the late AXI handshake(s) complete silently (no extra mem_valid_o).
REQ-027 Without it: no counter logic; the bridge waits indefinitely.

Structure
REQ-028 FSM state enum and AXI response constants (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11) SHALL live in the shared uninasoc package; no sub-module.

Verification
REQ-029 Read 0x0000_1000, slave rdata=0xDEADBEEF, rresp=OKAY, zero wait -> mem_valid_o at cycle 3, rdata 0xDEADBEEF, error 0.
REQ-030 Write 0x0000_2004, wdata=0x12345678, be=4'b0011; awready 2 cycles before wready -> single AW and W handshake, wstrb=0011, mem_valid_o once, error 0.
REQ-031 Read with rresp=DECERR -> mem_error_o=1 with mem_valid_o.
REQ-032 Back-to-back: mem_req_i held high for 3 requests -> exactly 3 grants, each only in IDLE, responses in order.
REQ-033 rst_i asserted while in RD_DATA -> no mem_valid_o, all outputs 0 next cycle, new read then completes normally.
REQ-034 MEM_AXIL_TIMEOUT_EN, TIMEOUT_CYCLES=16, bvalid withheld 40 cycles -> error response at cycle 16 after grant, no grant until bvalid handshake, no second mem_valid_o.
